apb_master_ctrl: RTL and testbench
==================================

Name: apb_master_ctrl

Overview:
- APB initiator (requester) that turns a simple valid/ready command port into APB SETUP/ACCESS transfers, one at a time.
- Returns read data and error status on a valid/ready response port.
- Sits upstream of SPI-side APB responders; used by test harnesses and by internal DMA/config sequencers to drive peripheral register banks.

Parameters:
- APB_ADDR_WIDTH, 32, width of address bus.
- APB_DATA_WIDTH, 32, width of read/write data buses.
- TIMEOUT_CYCLE, 16, max ACCESS cycles with apb_ready_in low before abort; legal range 1..255; used only with APB_TIMEOUT_EN.

Ports:
- apb_clk_in  in  1  sole clock; all logic on rising edge.
- apb_rst_in  in  1  asynchronous, active-high reset.
- cmd_valid_in  in  1  command request.
- cmd_ready_out  out  1  command accepted when both valid and ready are high.
- cmd_addr_in  in  APB_ADDR_WIDTH  target address.
- cmd_write_in  in  1  1 = write, 0 = read.
- cmd_wdata_in  in  APB_DATA_WIDTH  write data.
- rsp_valid_out  out  1  response available.
- rsp_ready_in  in  1  response consumed when both valid and ready are high.
- rsp_rdata_out  out  APB_DATA_WIDTH  read data; 0 for writes and for errors.
- rsp_error_out  out  1  transfer ended with slave error or timeout.
- apb_addr_out  out  APB_ADDR_WIDTH  PADDR.
- apb_psel_out  out  1  PSEL.
- apb_penable_out  out  1  PENABLE.
- apb_write_out  out  1  PWRITE.
- apb_wdata_out  out  APB_DATA_WIDTH  PWDATA.
- apb_rdata_in  in  APB_DATA_WIDTH  PRDATA.
- apb_ready_in  in  1  PREADY.
- apb_slverr_in  in  1  PSLVERR; sampled only when apb_ready_in is high in ACCESS.

Behaviour:
- Reset: asynchronous, active-high. While apb_rst_in is high, all outputs are 0 and the state is IDLE, with no gap.
- Reset mid-transfer: immediately deasserts psel/penable and drops any pending response. No transfer resumes after reset.
- All outputs are registered, except cmd_ready_out, which equals (state == IDLE).
- FSM, one-hot, states IDLE, SETUP, ACCESS, RESP:
  - IDLE: on cmd_valid_in & cmd_ready_out, latch addr/write/wdata onto the apb_* outputs, set psel=1 and penable=0, go to SETUP.
  - SETUP (exactly one cycle): set penable=1, go to ACCESS. addr/write/wdata are held stable from SETUP through the end of ACCESS.
  - ACCESS, when apb_ready_in=1:
    - capture rsp_rdata_out = write ? 0 : (apb_slverr_in ? 0 : apb_rdata_in)
    - set rsp_error_out = apb_slverr_in and rsp_valid_out = 1
    - set psel=0, penable=0; go to RESP
  - ACCESS, when apb_ready_in=0: stay in ACCESS with psel=1, penable=1.
  - RESP: hold rsp_* stable until rsp_ready_in=1; then clear rsp_valid_out and go to IDLE.
- apb_addr_out, apb_write_out and apb_wdata_out keep their last values in IDLE; no glitch-to-zero is required.
- Minimum latency:
  - command accepted at edge N: psel=1 from N+1, penable=1 from N+2
  - apb_ready_in high in the first ACCESS cycle: rsp_valid_out=1 from N+3
- Back-to-back throughput: one transfer per 4 cycles minimum (IDLE, SETUP, ACCESS, RESP with rsp_ready_in held high).
- cmd_valid_in during SETUP/ACCESS/RESP is ignored because cmd_ready_out=0. The command must be held until accepted.
- apb_slverr_in while apb_ready_in=0 is ignored.

Optional Feature:
Macro APB_TIMEOUT_EN.
- Defined:
  - An ACCESS-cycle counter, width $clog2(TIMEOUT_CYCLE+1), clears on entry to SETUP.
  - It increments each ACCESS cycle with apb_ready_in=0.
  - When the counter equals TIMEOUT_CYCLE with apb_ready_in=0, the transfer aborts: psel/penable=0, rsp_error_out=1, rsp_rdata_out=0, go to RESP.
  - If apb_ready_in=1 in the same cycle as timeout, the normal completion takes priority.
- Undefined: ACCESS waits indefinitely for apb_ready_in; no counter logic is synthesized; TIMEOUT_CYCLE is unused.

Decomposition:
- Shared package apb_pkg:
  - one-hot state index localparams (ST_IDLE=0, ST_SETUP=1, ST_ACCESS=2, ST_RESP=3) and the state vector width
  - the APB response-code constants (OKAY/ERROR), reused by the responder-side blocks
- One natural sub-module: apb_wait_timer (counter, clear, enable, timeout flag), instantiated only under APB_TIMEOUT_EN.

Test Plan:
1. Write, no wait: cmd addr=0x10, wdata=0xA5A5_5A5A, write=1; slave ready in first ACCESS -> psel at N+1, penable at N+2; rsp_valid at N+3 with error=0, rdata=0.
2. Read with 3 wait states: addr=0x24; ready low 3 ACCESS cycles, then high with prdata=0xDEAD_BEEF -> rsp_rdata=0xDEAD_BEEF, error=0; addr stable throughout ACCESS.
3. Slave error on read: ready=1 with slverr=1, prdata=0x1234 -> rsp_error=1, rsp_rdata=0. Slverr=1 while ready=0 has no effect.
4. Response backpressure: rsp_ready_in low 5 cycles -> rsp_* held stable, cmd_ready_out=0 throughout; a second command is accepted the cycle after the handshake.
5. Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLE=4): ready held low -> abort after 4 ACCESS cycles with rsp_error=1, psel=0. Ready=1 exactly on the 4th cycle -> normal completion, error=0.
6. Reset mid-ACCESS: assert apb_rst_in asynchronously (between clock edges) -> psel, penable and rsp_valid drop to 0 immediately; after release, IDLE with cmd_ready_out=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: one-hot FSM state indices/encoding and the
// response-code constants also used by the responder-side blocks.
package apb_pkg;

  localparam int unsigned ST_IDLE   = 0;
  localparam int unsigned ST_SETUP  = 1;
  localparam int unsigned ST_ACCESS = 2;
  localparam int unsigned ST_RESP   = 3;
  localparam int unsigned ST_W      = 4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE   = ST_W'(1 << ST_IDLE),
    S_SETUP  = ST_W'(1 << ST_SETUP),
    S_ACCESS = ST_W'(1 << ST_ACCESS),
    S_RESP   = ST_W'(1 << ST_RESP)
  } apb_state_e;

  // PSLVERR-style response codes
  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY and flags the cycle on which
// the wait budget is used up.
// Ports: clk/rst (async active-high), clr_in (restart count), en_in (a
// waiting ACCESS cycle), timeout_c (combinational: this waiting cycle is the
// LIMIT-th one, so the transfer must abort at the next edge).
module apb_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_in,
  input  logic en_in,
  output logic timeout_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // cnt_q holds waiting cycles already elapsed; it reaches LIMIT on the abort edge
  assign timeout_c = en_in && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (en_in) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: accepts one command at a time on a valid/ready port, runs
// the APB SETUP/ACCESS handshake and returns read data / error status on a
// valid/ready response port.
// Ports: apb_clk_in, apb_rst_in (async active-high); cmd_* command port;
// rsp_* response port; apb_* APB bus (PADDR/PSEL/PENABLE/PWRITE/PWDATA out,
// PRDATA/PREADY/PSLVERR in). cmd_ready_out is the only unregistered output.
// Build option: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLE
// cycles of PREADY low.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLE  = 16
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rst_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic                      cmd_write_in,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in,
  output logic                      rsp_valid_out,
  input  logic                      rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
  output logic                      rsp_error_out,
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
  output logic                      apb_psel_out,
  output logic                      apb_penable_out,
  output logic                      apb_write_out,
  output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
  input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
  input  logic                      apb_ready_in,
  input  logic                      apb_slverr_in
);

  if (TIMEOUT_CYCLE < 1 || TIMEOUT_CYCLE > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLE must be in 1..255");
  end

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      write_q, write_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_error_q, rsp_error_d;
  logic                      timeout_c;

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .LIMIT(TIMEOUT_CYCLE)
  ) u_wait_timer (
    .clk       (apb_clk_in),
    .rst       (apb_rst_in),
    .clr_in    (state_q == S_SETUP),
    .en_in     ((state_q == S_ACCESS) && !apb_ready_in),
    .timeout_c (timeout_c)
  );
`else
  assign timeout_c = 1'b0;
`endif

  // Reset gating keeps every output at 0 while reset is held
  assign cmd_ready_out = (state_q == S_IDLE) && !apb_rst_in;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          addr_d    = cmd_addr_in;
          write_d   = cmd_write_in;
          wdata_d   = cmd_wdata_in;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        // Normal completion wins over a timeout in the same cycle
        if (apb_ready_in) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = apb_slverr_in ? RESP_ERROR : RESP_OKAY;
          rsp_rdata_d = (write_q || apb_slverr_in) ? '0 : apb_rdata_in;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end else if (timeout_c) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = RESP_ERROR;
          rsp_rdata_d = '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_in) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge apb_clk_in or posedge apb_rst_in) begin
    if (apb_rst_in) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign apb_addr_out    = addr_q;
  assign apb_write_out   = write_q;
  assign apb_wdata_out   = wdata_q;
  assign apb_psel_out    = psel_q;
  assign apb_penable_out = penable_q;
  assign rsp_valid_out   = rsp_valid_q;
  assign rsp_rdata_out   = rsp_rdata_q;
  assign rsp_error_out   = rsp_error_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed transfers with a transaction-level
// timing/response model and a per-cycle compare process.
module tb_apb_master_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_master_ctrl #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLE (TO)
  ) dut (
    .apb_clk_in     (clk),
    .apb_rst_in     (rst),
    .cmd_valid_in   (cmd_valid),
    .cmd_ready_out  (cmd_ready),
    .cmd_addr_in    (cmd_addr),
    .cmd_write_in   (cmd_write),
    .cmd_wdata_in   (cmd_wdata),
    .rsp_valid_out  (rsp_valid),
    .rsp_ready_in   (rsp_ready),
    .rsp_rdata_out  (rsp_rdata),
    .rsp_error_out  (rsp_error),
    .apb_addr_out   (paddr),
    .apb_psel_out   (psel),
    .apb_penable_out(penable),
    .apb_write_out  (pwrite),
    .apb_wdata_out  (pwdata),
    .apb_rdata_in   (prdata),
    .apb_ready_in   (pready),
    .apb_slverr_in  (pslverr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Transaction model state: acc = cycle index of the SETUP cycle,
  // weff = wait cycles actually spent in ACCESS, dly = response stall cycles.
  int          acc = -100;
  int          weff = 0;
  int          dly = 0;
  logic [31:0] m_addr = '0;
  logic        m_write = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Response rule from the protocol description, including timeout abort
  task automatic model(input logic wr, input int w, input logic err, input logic [31:0] pr);
    weff    = w;
    m_err   = err;
    m_rdata = (wr || err) ? 32'h0 : pr;
`ifdef APB_TIMEOUT_EN
    if (w >= int'(TO)) begin
      weff    = int'(TO) - 1;
      m_err   = 1'b1;
      m_rdata = 32'h0;
    end
`endif
  endtask

  // Per-cycle compare against the model's timing windows
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      logic in_psel, in_pen, in_rsp, busy;
      in_psel = (cyc >= acc) && (cyc <= acc + 1 + weff);
      in_pen  = (cyc >= acc + 1) && (cyc <= acc + 1 + weff);
      in_rsp  = (cyc >= acc + 2 + weff) && (cyc <= acc + 2 + weff + dly);
      busy    = (cyc >= acc) && (cyc <= acc + 2 + weff + dly);
      chk("psel", 32'(psel), 32'(in_psel));
      chk("penable", 32'(penable), 32'(in_pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(in_rsp));
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
      if (in_psel) begin
        chk("paddr", paddr, m_addr);
        chk("pwrite", 32'(pwrite), 32'(m_write));
        chk("pwdata", pwdata, m_wdata);
      end
      if (in_rsp) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_error", 32'(rsp_error), 32'(m_err));
      end
    end
  end

  // One transfer, started at a negedge while the DUT is idle.
  // w: ACCESS cycle (0-based) on which PREADY rises; err_wait: PSLVERR during waits.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input int w, input logic [31:0] pr, input logic err,
                      input logic err_wait, input int d,
                      output logic [31:0] got_rd, output logic got_err);
    model(wr, w, err, pr);
    m_addr  = a;
    m_write = wr;
    m_wdata = wd;
    dly     = d;
    acc     = cyc + 1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = wr;
    cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'h0;
    for (int k = 0; k <= weff; k++) begin
      @(negedge clk);
      pready  = (k == w);
      pslverr = (k == w) ? err : err_wait;
      prdata  = (k == w) ? pr : 32'h0BAD_0BAD;
    end
    got_rd  = 32'h0;
    got_err = 1'b0;
    for (int j = 0; j <= d; j++) begin
      @(negedge clk);
      pready    = 1'b0;
      pslverr   = 1'b0;
      rsp_ready = (j == d);
      if (j == d) begin
        got_rd  = rsp_rdata;
        got_err = rsp_error;
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    // Reset: every output low while reset is held
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // 1: write, no wait
    xfer(32'h10, 1'b1, 32'hA5A5_5A5A, 0, 32'h7777_7777, 1'b0, 1'b0, 0, rd, er);
    chk("t1_rdata", rd, 32'h0);
    chk("t1_error", 32'(er), 32'h0);

    // 2: read with 3 wait states
    xfer(32'h24, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, rd, er);
    chk("t2_rdata", rd, 32'hDEAD_BEEF);
    chk("t2_error", 32'(er), 32'h0);

    // 3: slave error on read; PSLVERR during waits ignored
    xfer(32'h28, 1'b0, 32'h0, 0, 32'h1234, 1'b1, 1'b0, 0, rd, er);
    chk("t3_rdata", rd, 32'h0);
    chk("t3_error", 32'(er), 32'h1);
    xfer(32'h2C, 1'b0, 32'h0, 2, 32'h0000_5678, 1'b0, 1'b1, 0, rd, er);
    chk("t3b_rdata", rd, 32'h0000_5678);
    chk("t3b_error", 32'(er), 32'h0);

    // 4: response backpressure, then an immediate second command
    xfer(32'h30, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 5, rd, er);
    chk("t4_rdata", rd, 32'hCAFE_F00D);
    xfer(32'h34, 1'b1, 32'h1357_9BDF, 0, 32'h0, 1'b0, 1'b0, 0, rd, er);
    chk("t4b_error", 32'(er), 32'h0);
    xfer(32'h38, 1'b0, 32'h0, 0, 32'h0246_8ACE, 1'b0, 1'b0, 0, rd, er);
    chk("t4c_rdata", rd, 32'h0246_8ACE);

`ifdef APB_TIMEOUT_EN
    // 5: timeout abort, and completion on the last allowed cycle
    xfer(32'h40, 1'b0, 32'h0, 20, 32'h1111_1111, 1'b0, 1'b0, 0, rd, er);
    chk("t5_abort_error", 32'(er), 32'h1);
    chk("t5_abort_rdata", rd, 32'h0);
    xfer(32'h44, 1'b0, 32'h0, int'(TO) - 1, 32'h2222_2222, 1'b0, 1'b0, 0, rd, er);
    chk("t5_edge_error", 32'(er), 32'h0);
    chk("t5_edge_rdata", rd, 32'h2222_2222);
`endif

    // 6: asynchronous reset in the middle of ACCESS
    model(1'b0, 10, 1'b0, 32'h0);
    m_addr = 32'h50; m_write = 1'b0; m_wdata = 32'h0; dly = 0;
    acc = cyc + 1;
    cmd_valid = 1'b1; cmd_addr = 32'h50; cmd_write = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_psel", 32'(psel), 32'h0);
    chk("t6_penable", 32'(penable), 32'h0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("t6_cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    acc = -100;
    weff = 0;
    @(negedge clk);
    chk("t6_idle_ready", 32'(cmd_ready), 32'h1);
    chk("t6_idle_psel", 32'(psel), 32'h0);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    xfer(32'h54, 1'b0, 32'h0, 1, 32'h8765_4321, 1'b0, 1'b0, 1, rd, er);
    chk("t6_after_rdata", rd, 32'h8765_4321);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
